// File: rtl/serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_tx_pkg
// Shared definitions for the serial transmit scheduler:
//   - state_e          : scheduler FSM state encoding (2 bits)
//   - FRAME_CYCLES_DEF : default number of cycles reserved per serial frame
//   - FRAME_CYCLES_MIN : shortest legal frame (marker bit + 8 data bits)
//   - BYTE_W           : width of one requester byte
// -----------------------------------------------------------------------------
package serial_tx_pkg;

   localparam int BYTE_W           = 8;
   localparam int FRAME_CYCLES_DEF = 10;
   localparam int FRAME_CYCLES_MIN = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_FIRE  = 2'd2,
      ST_WAIT  = 2'd3
   } state_e;

endpackage : serial_tx_pkg

// File: rtl/serial_tx_sched_arb.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: starting at ptr_i and wrapping upward, the
// first set request bit wins.
//
// Ports:
//   req_i    in   [N_REQ]  request vector
//   ptr_i    in   [IDX_W]  lane at which the search starts
//   grant_o  out  [N_REQ]  one-hot winner (zero when no request)
//   idx_o    out  [IDX_W]  winner index (zero when no request)
//   valid_o  out  1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   always_comb begin
      int j;
      j       = 0;
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(ptr_i) + k) % N_REQ;
         if (!valid_o && req_i[IDX_W'(j)]) begin
            valid_o               = 1'b1;
            idx_o                 = IDX_W'(j);
            grant_o[IDX_W'(j)]    = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/serial_tx_sched.sv
// -----------------------------------------------------------------------------
// serial_tx_sched
// Round-robin scheduler sharing one 8-bit serializer between N_REQ requesters.
// A grant captures the winner's byte onto PDout, pulses that requester's Ack,
// then raises Send for one cycle and holds off further launches until the
// frame interval has elapsed.
//
// Ports:
//   Clk      in   system clock, rising edge
//   Rst      in   synchronous active-high reset
//   Req      in   [N_REQ]      level request per requester
//   Data     in   [8*N_REQ]    requester i byte at Data[8i+7:8i]
//   Ack      out  [N_REQ]      one-cycle pulse to the granted requester
//   GrantIdx out  [clog2 N_REQ] index of the most recent grant
//   Busy     out  1            high whenever the scheduler is not idle
//   Send     out  1            serializer launch strobe (rising edge)
//   PDout    out  8            byte presented to the serializer
// -----------------------------------------------------------------------------
module serial_tx_sched
   import serial_tx_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic [N_REQ-1:0]           Req,
   input  logic [BYTE_W*N_REQ-1:0]    Data,
   output logic [N_REQ-1:0]           Ack,
   output logic [$clog2(N_REQ)-1:0]   GrantIdx,
   output logic                       Busy,
   output logic                       Send,
   output logic [BYTE_W-1:0]          PDout
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(FRAME_CYCLES);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_REQ - 1);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    ptr_d;
   logic [N_REQ-1:0]    ack_q;
   logic [IDX_W-1:0]    gidx_q;
   logic                send_q;
   logic [BYTE_W-1:0]   pdout_q;

   logic [N_REQ-1:0]    arb_grant;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_valid;
   logic [BYTE_W-1:0]   data_lane [N_REQ];
   logic [BYTE_W-1:0]   sel_byte;

   // Split the flat data bus into one byte per requester.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign data_lane[gi] = Data[gi*BYTE_W +: BYTE_W];
   end

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i   (Req),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   assign sel_byte = data_lane[arb_idx];

   // Next search start is the lane after the winner, wrapping to 0.
   assign ptr_d = (arb_idx == IDX_LAST) ? '0 : arb_idx + IDX_W'(1);

   // The frame counter is loaded on entry to FIRE, so the Send cycle itself
   // is the first of the FRAME_CYCLES reserved for the frame. Reset enters
   // WAIT with the same count, which leaves one extra cycle of drain time
   // for a frame that may still be shifting out of the serializer.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_WAIT;
         cnt_q   <= FRAME_LAST;
         ptr_q   <= '0;
         ack_q   <= '0;
         gidx_q  <= '0;
         send_q  <= 1'b0;
         pdout_q <= '0;
      end else begin
         ack_q  <= '0;
         send_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (arb_valid) begin
                  pdout_q <= sel_byte;
                  ack_q   <= arb_grant;
                  gidx_q  <= arb_idx;
                  ptr_q   <= ptr_d;
                  state_q <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               // PDout has been stable for a full cycle; launch next edge.
               send_q  <= 1'b1;
               cnt_q   <= FRAME_LAST;
               state_q <= ST_FIRE;
            end
            ST_FIRE: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_WAIT;
               cnt_q   <= FRAME_LAST;
            end
         endcase
      end
   end

   assign Ack      = ack_q;
   assign GrantIdx = gidx_q;
   assign Busy     = (state_q != ST_IDLE);
   assign Send     = send_q;
   assign PDout    = pdout_q;

endmodule : serial_tx_sched
